// File: rtl/note_poly.sv
// note_poly: polyphonic note allocator sitting between the MIDI decoder and a
// bank of VOICES voice/envelope pairs.
//   clk, rst          : system clock, synchronous active-high reset
//   note_on, note_off : message-present levels; only rising edges are events
//   note, vel         : note number and velocity (note-on with vel==0 is an off)
//   out_note          : per-voice note, voice i in bits [7*i+6:7*i]
//   out_gate          : per-voice gate
//   out_retrig        : one-cycle pulse when a voice is (re)assigned
//   active_cnt        : registered popcount of out_gate (one cycle behind)
// Free voices are used first; when all are busy the oldest is stolen with a
// one-cycle gate gap so its envelope retriggers cleanly.
module note_poly #(
  parameter int VOICES = 4,
  parameter int AGE_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  note_on,
  input  logic                  note_off,
  input  logic [6:0]            note,
  input  logic [6:0]            vel,
  output logic [7*VOICES-1:0]   out_note,
  output logic [VOICES-1:0]     out_gate,
  output logic [VOICES-1:0]     out_retrig,
  output logic [3:0]            active_cnt
);
  localparam int IDX_W = $clog2(VOICES);

  typedef enum logic {IDLE, STEAL_GAP} state_t;

  state_t               state_q, state_d;
  logic                 on_q, off_q;
  logic                 pend_on_q, pend_on_d, pend_off_q, pend_off_d;
  logic [6:0]           pend_note_q, pend_note_d;
  logic [6:0]           note_q [VOICES];
  logic [6:0]           note_d [VOICES];
  logic [AGE_W-1:0]     age_q  [VOICES];
  logic [AGE_W-1:0]     age_d  [VOICES];
  logic [VOICES-1:0]    gate_q, gate_d, retrig_q, retrig_d;
  logic [IDX_W-1:0]     victim_q, victim_d;
  logic [3:0]           cnt_q, cnt_d;

  logic                 on_edge, off_edge, cur_on, cur_off, use_pend;
  logic                 ev_on, ev_off;
  logic [6:0]           ev_note;
  logic                 found_hit, found_free;
  logic [IDX_W-1:0]     hit_idx, free_idx, old_idx, tgt_idx;

  always_comb begin
    on_edge  = note_on & ~on_q;
    off_edge = note_off & ~off_q;
    // Velocity is folded into the event type here, so the pending slot only
    // needs to carry the note number.
    cur_on   = on_edge & (vel != 7'd0);
    cur_off  = off_edge | (on_edge & (vel == 7'd0));
    use_pend = pend_on_q | pend_off_q;

    state_d     = state_q;
    gate_d      = gate_q;
    retrig_d    = '0;
    victim_d    = victim_q;
    note_d      = note_q;
    age_d       = age_q;
    found_hit   = 1'b0;
    found_free  = 1'b0;
    hit_idx     = '0;
    free_idx    = '0;
    old_idx     = '0;
    tgt_idx     = '0;

    // A pending event is always consumed before fresh edges; fresh edges that
    // arrive meanwhile (or during the steal gap) take the single pending slot.
    ev_on   = 1'b0;
    ev_off  = 1'b0;
    ev_note = note;
    if (state_q == IDLE) begin
      if (use_pend) begin
        ev_on   = pend_on_q;
        ev_off  = pend_off_q;
        ev_note = pend_note_q;
      end else begin
        ev_on   = cur_on;
        ev_off  = cur_off;
      end
    end

    pend_on_d   = 1'b0;
    pend_off_d  = 1'b0;
    pend_note_d = pend_note_q;
    if (state_q == STEAL_GAP || use_pend) begin
      if (cur_on || cur_off) begin
        pend_on_d   = cur_on;
        pend_off_d  = cur_off;
        pend_note_d = note;
      end else if (state_q == STEAL_GAP) begin
        pend_on_d  = pend_on_q;
        pend_off_d = pend_off_q;
      end
    end

    if (state_q == STEAL_GAP) begin
      gate_d[victim_q]   = 1'b1;
      retrig_d[victim_q] = 1'b1;
      state_d            = IDLE;
    end else begin
      // Off first, so a same-cycle on-event sees the freed voice.
      if (ev_off) begin
        for (int i = 0; i < VOICES; i++) begin
          if (gate_q[i] && note_q[i] == ev_note) gate_d[i] = 1'b0;
        end
      end
      if (ev_on) begin
        for (int i = VOICES - 1; i >= 0; i--) begin
          if (gate_d[i] && note_q[i] == ev_note) begin
            found_hit = 1'b1;
            hit_idx   = IDX_W'(i);
          end
          if (!gate_d[i]) begin
            found_free = 1'b1;
            free_idx   = IDX_W'(i);
          end
        end
        // Strict compare keeps the lowest index on equal ages.
        for (int i = 1; i < VOICES; i++) begin
          if (age_q[i] > age_q[old_idx]) old_idx = IDX_W'(i);
        end
        tgt_idx = found_hit ? hit_idx : (found_free ? free_idx : old_idx);
        for (int i = 0; i < VOICES; i++) begin
          if (IDX_W'(i) == tgt_idx) age_d[i] = '0;
          else if (age_q[i] != {AGE_W{1'b1}}) age_d[i] = age_q[i] + AGE_W'(1);
        end
        note_d[tgt_idx] = ev_note;
        if (found_hit || found_free) begin
          gate_d[tgt_idx]   = 1'b1;
          retrig_d[tgt_idx] = 1'b1;
        end else begin
          gate_d[tgt_idx] = 1'b0;
          victim_d        = tgt_idx;
          state_d         = STEAL_GAP;
        end
      end
    end

    cnt_d = '0;
    for (int i = 0; i < VOICES; i++) cnt_d = cnt_d + 4'(gate_q[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      on_q        <= 1'b0;
      off_q       <= 1'b0;
      pend_on_q   <= 1'b0;
      pend_off_q  <= 1'b0;
      pend_note_q <= '0;
      gate_q      <= '0;
      retrig_q    <= '0;
      victim_q    <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < VOICES; i++) begin
        note_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      on_q        <= note_on;
      off_q       <= note_off;
      pend_on_q   <= pend_on_d;
      pend_off_q  <= pend_off_d;
      pend_note_q <= pend_note_d;
      gate_q      <= gate_d;
      retrig_q    <= retrig_d;
      victim_q    <= victim_d;
      cnt_q       <= cnt_d;
      note_q      <= note_d;
      age_q       <= age_d;
    end
  end

  for (genvar gi = 0; gi < VOICES; gi++) begin : g_note_out
    assign out_note[7*gi +: 7] = note_q[gi];
  end
  assign out_gate   = gate_q;
  assign out_retrig = retrig_q;
  assign active_cnt = cnt_q;
endmodule

// File: tb/tb_note_poly.sv
module tb_note_poly;
  localparam int VOICES = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                note_on = 1'b0;
  logic                note_off = 1'b0;
  logic [6:0]          note = '0;
  logic [6:0]          vel = '0;
  logic [7*VOICES-1:0] out_note;
  logic [VOICES-1:0]   out_gate;
  logic [VOICES-1:0]   out_retrig;
  logic [3:0]          active_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  note_poly #(.VOICES(VOICES), .AGE_W(8)) dut (
    .clk(clk), .rst(rst), .note_on(note_on), .note_off(note_off),
    .note(note), .vel(vel), .out_note(out_note), .out_gate(out_gate),
    .out_retrig(out_retrig), .active_cnt(active_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Returns 1 ns after the next rising edge, so outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] vnote(input int v);
    return out_note[7*v +: 7];
  endfunction

  task automatic do_reset();
    note_on = 0; note_off = 0; rst = 1;
    step(); step();
    $display("reset");
  endtask

  // Idle cycle, then a one-cycle note_on; returns with the k+1 outputs visible.
  task automatic press(input logic [6:0] n, input logic [6:0] v);
    step();
    rst = 0; note = n; vel = v; note_on = 1;
    step();
    note_on = 0;
    $display("note_on  note=%0d vel=%0d gate=%b retrig=%b", n, v, out_gate, out_retrig);
  endtask

  task automatic release_note(input logic [6:0] n);
    step();
    note = n; note_off = 1;
    step();
    note_off = 0;
    $display("note_off note=%0d gate=%b", n, out_gate);
  endtask

  task automatic fill4();
    press(7'd60, 7'd100); press(7'd62, 7'd100);
    press(7'd64, 7'd100); press(7'd65, 7'd100);
  endtask

  initial begin
    // 1: reset state and first allocation
    do_reset();
    check("rst_gate", 32'(out_gate), 0);
    check("rst_note", 32'(out_note), 0);
    check("rst_retrig", 32'(out_retrig), 0);
    check("rst_cnt", 32'(active_cnt), 0);
    press(7'd60, 7'd100);
    check("t1_gate", 32'(out_gate), 32'b0001);
    check("t1_note0", 32'(vnote(0)), 60);
    check("t1_retrig", 32'(out_retrig), 32'b0001);
    check("t1_cnt_lag", 32'(active_cnt), 0);
    step();
    check("t1_retrig_end", 32'(out_retrig), 0);
    check("t1_cnt", 32'(active_cnt), 1);

    // 2: free-voice reuse after note-off
    press(7'd62, 7'd100); press(7'd64, 7'd100); press(7'd65, 7'd100);
    check("t2_full", 32'(out_gate), 32'b1111);
    step();
    check("t2_cnt4", 32'(active_cnt), 4);
    release_note(7'd62);
    check("t2_off_gate", 32'(out_gate), 32'b1101);
    check("t2_off_note1", 32'(vnote(1)), 62);
    press(7'd67, 7'd100);
    check("t2_reuse_gate", 32'(out_gate), 32'b1111);
    check("t2_reuse_note1", 32'(vnote(1)), 67);
    check("t2_reuse_retrig", 32'(out_retrig), 32'b0010);

    // 3: steal oldest (voice0, ages 4,0,2,1)
    press(7'd70, 7'd100);
    check("t3_gap_gate", 32'(out_gate), 32'b1110);
    check("t3_gap_note0", 32'(vnote(0)), 70);
    check("t3_gap_retrig", 32'(out_retrig), 0);
    step();
    check("t3_rise_gate", 32'(out_gate), 32'b1111);
    check("t3_rise_retrig", 32'(out_retrig), 32'b0001);
    step();
    check("t3_retrig_end", 32'(out_retrig), 0);

    // 4: repeated note retriggers the same voice
    do_reset();
    press(7'd60, 7'd100);
    check("t4_first_retrig", 32'(out_retrig), 32'b0001);
    press(7'd60, 7'd90);
    check("t4_gate", 32'(out_gate), 32'b0001);
    check("t4_second_retrig", 32'(out_retrig), 32'b0001);
    step();
    check("t4_cnt", 32'(active_cnt), 1);

    // 5a: velocity-zero note-on acts as note-off
    press(7'd60, 7'd0);
    check("t5_vel0_gate", 32'(out_gate), 0);
    check("t5_vel0_note", 32'(vnote(0)), 60);
    // 5b: simultaneous off+on with all voices busy reuses the freed voice
    do_reset();
    fill4();
    step();
    note = 7'd60; vel = 7'd100; note_on = 1; note_off = 1;
    step();
    note_on = 0; note_off = 0;
    $display("note_on+off note=60 gate=%b retrig=%b", out_gate, out_retrig);
    check("t5_both_gate", 32'(out_gate), 32'b1111);
    check("t5_both_retrig", 32'(out_retrig), 32'b0001);
    step();
    check("t5_no_steal", 32'(out_gate), 32'b1111);

    // 6a: reset during the steal gap
    do_reset();
    fill4();
    press(7'd67, 7'd100);
    check("t6_gap_gate", 32'(out_gate), 32'b1110);
    rst = 1;
    step();
    check("t6_rst_gate", 32'(out_gate), 0);
    check("t6_rst_note", 32'(out_note), 0);
    check("t6_rst_retrig", 32'(out_retrig), 0);
    rst = 0;
    step();
    check("t6_after_gate", 32'(out_gate), 0);
    check("t6_after_cnt", 32'(active_cnt), 0);
    // 6b: note-off for the stolen-in note arriving during the gap
    fill4();
    press(7'd67, 7'd100);
    check("t6b_gap_gate", 32'(out_gate), 32'b1110);
    note = 7'd67; note_off = 1;
    step();
    note_off = 0;
    check("t6b_rise_gate", 32'(out_gate), 32'b1111);
    check("t6b_rise_retrig", 32'(out_retrig), 32'b0001);
    step();
    check("t6b_pend_off_gate", 32'(out_gate), 32'b1110);
    check("t6b_pend_off_note", 32'(vnote(0)), 67);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
